// File: rtl/muxn_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_pkg                                                                    |
// | Shared constants and index helpers for the muxn_reg N:1 registered mux.    |
// | MODE_EXT selects the externally driven channel select, and MODE_RR selects |
// | the internal round-robin arbitration.                                      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package mux_pkg;

  localparam int unsigned MODE_EXT = 0;
  localparam int unsigned MODE_RR  = 1;

  // Wide index type used for channel arithmetic. Values are truncated to SELW
  // bits only after wrap handling, so a non-power-of-2 N never aliases.
  typedef logic [31:0] sel_idx_t;

  // Increment a channel index and wrap it explicitly at n (not at 2**SELW).
  function automatic sel_idx_t wrap_inc(input sel_idx_t idx, input int unsigned n);
    sel_idx_t nxt;
    nxt = idx + sel_idx_t'(1);
    return (nxt >= sel_idx_t'(n)) ? '0 : nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muxn_reg_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muxn_reg_if                                                                |
// | Bundle of the N input channels, the select and the output channel.         |
// |   in_data/in_valid/in_ready : per-channel producer handshake               |
// |   sel                       : external channel select (MODE_EXT only)      |
// |   out_data/out_valid/out_ready/out_src : registered consumer handshake     |
// | master = producer/consumer side, slave = mux side.                         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface muxn_reg_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned SELW  = $clog2(N)
);

  logic [N-1:0][WIDTH-1:0] in_data;
  logic [N-1:0]            in_valid;
  logic [N-1:0]            in_ready;
  logic [SELW-1:0]         sel;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [SELW-1:0]         out_src;

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_valid, out_src
  );

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_valid, out_src
  );

endinterface
`default_nettype wire

// File: rtl/muxn_reg_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_pick                                                                    |
// | Combinational round-robin picker. Finds the first asserted req bit that    |
// | starts at ptr and searches upward, then wraps from N-1 to 0.               |
// |   req     [N-1:0]    : request vector                                      |
// |   ptr     [SELW-1:0] : highest-priority index (assumed < N)                |
// |   gnt_idx [SELW-1:0] : granted index (0 when gnt_any is low)               |
// |   gnt_any            : at least one request present                        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  sel_idx_t w_idx;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    w_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      // Rotate by ptr with an explicit wrap at N so non-power-of-2 N is exact.
      w_idx = sel_idx_t'(ptr) + sel_idx_t'(i);
      if (w_idx >= sel_idx_t'(N)) begin
        w_idx = w_idx - sel_idx_t'(N);
      end
      if (!gnt_any && req[w_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muxn_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | muxn_reg                                                                   |
// | N-input, WIDTH-bit multiplexer with a single-entry registered output stage |
// | and valid/ready handshakes on every input and on the output.              |
// |   clk   : rising-edge clock                                                |
// |   reset : asynchronous assert, active-high; clears the output stage and    |
// |           the round-robin pointer                                          |
// |   bus   : muxn_reg_if slave (inputs, sel, outputs)                         |
// | MODE_EXT: channel chosen by bus.sel. MODE_RR: round-robin among valids.    |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module muxn_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned N     = 4,
  parameter int unsigned MODE  = MODE_EXT,
  parameter int unsigned SELW  = $clog2(N)
) (
  input  logic       clk,
  input  logic       reset,
  muxn_reg_if.slave  bus
);

  logic             w_load_en;
  logic             w_gnt_any;
  logic [SELW-1:0]  w_gnt;
  logic             w_load;
  logic [N-1:0]     w_in_ready;

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SELW-1:0]  r_out_src;

  // The output stage can take a word when it is empty or is draining this cycle.
  assign w_load_en = !r_out_valid || bus.out_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] r_ptr;
      logic [SELW-1:0] w_rr_idx;
      logic            w_rr_any;

      rr_pick #(
        .N    (N),
        .SELW (SELW)
      ) u_pick (
        .req     (bus.in_valid),
        .ptr     (r_ptr),
        .gnt_idx (w_rr_idx),
        .gnt_any (w_rr_any)
      );

      assign w_gnt     = w_rr_idx;
      assign w_gnt_any = w_rr_any;

      // The pointer moves past the winner only on an accepted transfer, so a
      // stalled grant keeps its priority.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_ptr <= '0;
        end else if (w_load) begin
          r_ptr <= SELW'(wrap_inc(sel_idx_t'(w_gnt), N));
        end
      end
    end else begin : g_ext
      // An out-of-range select grants nothing, so in_ready stays low and no
      // load occurs.
      assign w_gnt     = bus.sel;
      assign w_gnt_any = (sel_idx_t'(bus.sel) < sel_idx_t'(N));
    end
  endgenerate

  // In external mode the ready bit ignores in_valid of the chosen channel.
  always_comb begin
    w_in_ready = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_in_ready[k] = w_gnt_any && (w_gnt == SELW'(k)) && w_load_en;
    end
  end

  assign w_load = w_gnt_any && w_load_en && bus.in_valid[w_gnt];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data[w_gnt];
      r_out_src   <= w_gnt;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_src   = r_out_src;

endmodule
`default_nettype wire

// File: tb/tb_muxn_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_muxn_reg                                                                |
// | Bench for muxn_reg. It uses four builds: N=4 external select, N=4 round-   |
// | robin, N=3 round-robin and N=3 external select. The bench compares each    |
// | build with a per-build behavioural model and a FIFO scoreboard.            |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_muxn_reg;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus per build (index 0..3). 3-channel builds use the low slices.
  logic [3:0][63:0] td    [4];
  logic [3:0]       t_val [4];
  logic [1:0]       t_sel [4];
  logic             t_rdy [4];

  muxn_reg_if #(.WIDTH(64), .N(4)) b0 ();
  muxn_reg_if #(.WIDTH(64), .N(4)) b1 ();
  muxn_reg_if #(.WIDTH(64), .N(3)) b2 ();
  muxn_reg_if #(.WIDTH(64), .N(3)) b3 ();

  assign b0.in_data = td[0];      assign b0.in_valid = t_val[0];
  assign b0.sel     = t_sel[0];   assign b0.out_ready = t_rdy[0];
  assign b1.in_data = td[1];      assign b1.in_valid = t_val[1];
  assign b1.sel     = t_sel[1];   assign b1.out_ready = t_rdy[1];
  assign b2.in_data = td[2][2:0]; assign b2.in_valid = t_val[2][2:0];
  assign b2.sel     = t_sel[2];   assign b2.out_ready = t_rdy[2];
  assign b3.in_data = td[3][2:0]; assign b3.in_valid = t_val[3][2:0];
  assign b3.sel     = t_sel[3];   assign b3.out_ready = t_rdy[3];

  muxn_reg #(.WIDTH(64), .N(4), .MODE(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  muxn_reg #(.WIDTH(64), .N(4), .MODE(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  muxn_reg #(.WIDTH(64), .N(3), .MODE(1)) u2 (.clk(clk), .reset(reset), .bus(b2));
  muxn_reg #(.WIDTH(64), .N(3), .MODE(0)) u3 (.clk(clk), .reset(reset), .bus(b3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // DUT output accessors
  function automatic logic [3:0] dut_rdy(input int d);
    case (d)
      0:       return b0.in_ready;
      1:       return b1.in_ready;
      2:       return {1'b0, b2.in_ready};
      default: return {1'b0, b3.in_ready};
    endcase
  endfunction
  function automatic logic dut_v(input int d);
    case (d)
      0: return b0.out_valid; 1: return b1.out_valid;
      2: return b2.out_valid; default: return b3.out_valid;
    endcase
  endfunction
  function automatic logic [63:0] dut_data(input int d);
    case (d)
      0: return b0.out_data; 1: return b1.out_data;
      2: return b2.out_data; default: return b3.out_data;
    endcase
  endfunction
  function automatic logic [1:0] dut_src(input int d);
    case (d)
      0: return b0.out_src; 1: return b1.out_src;
      2: return b2.out_src; default: return b3.out_src;
    endcase
  endfunction

  function automatic int n_of(input int d);
    return (d < 2) ? 4 : 3;
  endfunction
  function automatic bit rr_of(input int d);
    return (d == 1) || (d == 2);
  endfunction

  // Reference model state: output stage contents and round-robin pointer.
  bit          mv [4];
  logic [63:0] md [4];
  int          ms [4];
  int          mp [4];

  // Scoreboard: the accepted words in order, one ring per build.
  logic [65:0] sb [4][64];
  int          wp [4];
  int          rp [4];

  task automatic model_reset();
    for (int d = 0; d < 4; d++) begin
      mv[d] = 1'b0; md[d] = '0; ms[d] = 0; mp[d] = 0; wp[d] = 0; rp[d] = 0;
    end
  endtask

  // Channel the rules grant this cycle, or -1.
  function automatic int grant(input int d);
    int n;
    int k;
    n = n_of(d);
    if (!rr_of(d)) begin
      return (int'(t_sel[d]) < n) ? int'(t_sel[d]) : -1;
    end
    for (int i = 0; i < n; i++) begin
      k = (mp[d] + i) % n;
      if (t_val[d][k]) return k;
    end
    return -1;
  endfunction

  // One clock: check combinational readies and output handshakes, then the
  // registered state after the edge. The caller sets inputs before calling.
  task automatic step();
    int          g     [4];
    bit          ld    [4];
    logic [63:0] ldat  [4];
    bit          le;
    logic [3:0]  er;
    logic [65:0] e;
    #1;
    for (int d = 0; d < 4; d++) begin
      g[d] = grant(d);
      le   = !mv[d] || t_rdy[d];
      er   = (g[d] >= 0 && le) ? 4'(1 << g[d]) : 4'b0;
      chk($sformatf("d%0d_in_ready", d), 64'(dut_rdy(d)), 64'(er));
      ld[d]   = le && (g[d] >= 0) && t_val[d][(g[d] >= 0) ? g[d] : 0];
      ldat[d] = td[d][(g[d] >= 0) ? g[d] : 0];
      if (dut_v(d) && t_rdy[d]) begin
        if (wp[d] == rp[d]) begin
          chk($sformatf("d%0d_sb_occupancy", d), 64'(wp[d] - rp[d]), 64'd1);
        end else begin
          e = sb[d][rp[d] % 64];
          rp[d]++;
          chk($sformatf("d%0d_sb_data", d), dut_data(d), e[63:0]);
          chk($sformatf("d%0d_sb_src", d), 64'(dut_src(d)), 64'(e[65:64]));
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      if (ld[d]) begin
        sb[d][wp[d] % 64] = {2'(g[d]), ldat[d]};
        wp[d]++;
        mv[d] = 1'b1;
        md[d] = ldat[d];
        ms[d] = g[d];
        if (rr_of(d)) mp[d] = (g[d] + 1) % n_of(d);
      end else if (mv[d] && t_rdy[d]) begin
        mv[d] = 1'b0;
      end
      chk($sformatf("d%0d_out_valid", d), 64'(dut_v(d)), 64'(mv[d]));
      chk($sformatf("d%0d_out_data", d), dut_data(d), md[d]);
      chk($sformatf("d%0d_out_src", d), 64'(dut_src(d)), 64'(ms[d]));
    end
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < 4; d++) begin
      td[d] = '0; t_val[d] = '0; t_sel[d] = '0; t_rdy[d] = 1'b1;
    end
  endtask

  int exp_seq1 [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};

  initial begin
    reset = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d_rst_valid", d), 64'(dut_v(d)), 64'd0);
      chk($sformatf("d%0d_rst_data", d), dut_data(d), 64'd0);
      chk($sformatf("d%0d_rst_src", d), 64'(dut_src(d)), 64'd0);
    end
    reset = 1'b0;

    // External select: a single word on channel 2.
    t_sel[0] = 2'd2; t_val[0] = 4'b0100; td[0][2] = 64'hDEAD_BEEF;
    step();
    chk("t1_valid", 64'(b0.out_valid), 64'd1);
    chk("t1_data", b0.out_data, 64'hDEAD_BEEF);
    chk("t1_src", 64'(b0.out_src), 64'd2);
    chk("t1_in_ready", 64'(b0.in_ready), 64'b0100);

    // Stall: the held word and its source stay put while the input changes.
    t_rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      td[0][2] = 64'(i + 100);
      step();
      chk("stall_data", b0.out_data, 64'hDEAD_BEEF);
      chk("stall_in_ready", 64'(b0.in_ready), 64'd0);
    end
    t_rdy[0] = 1'b1; td[0][2] = 64'h1234;
    step();
    chk("nobubble_valid", 64'(b0.out_valid), 64'd1);
    chk("nobubble_data", b0.out_data, 64'h1234);
    t_val[0] = '0;

    // Round robin: N=4 all valid then channels 1,3 only; N=3 all valid (wrap).
    t_val[1] = 4'b1111; t_val[2] = 4'b0111;
    for (int i = 0; i < 9; i++) begin
      if (i == 5) t_val[1] = 4'b1010;
      td[1] = {64'(40 + i), 64'(30 + i), 64'(20 + i), 64'(10 + i)};
      td[2] = {64'd0, 64'(70 + i), 64'(60 + i), 64'(50 + i)};
      step();
      chk("rr4_src", 64'(b1.out_src), 64'(exp_seq1[i]));
      chk("rr3_src", 64'(b2.out_src), 64'(i % 3));
    end
    t_val[1] = '0; t_val[2] = '0;

    // Out-of-range select on a 3-channel build.
    t_sel[3] = 2'd3; t_val[3] = 4'b0111; td[3] = {64'd4, 64'd3, 64'd2, 64'd1};
    step();
    step();
    chk("sel3_in_ready", 64'(b3.in_ready), 64'd0);
    chk("sel3_valid", 64'(b3.out_valid), 64'd0);
    t_val[3] = '0;

    // Asynchronous reset mid-stall. The output and the pointer clear before the edge.
    t_rdy[0] = 1'b0; t_sel[0] = 2'd2; t_val[0] = 4'b0100; td[0][2] = 64'h5555;
    t_val[1] = 4'b0001; td[1][0] = 64'h77;
    step();
    chk("pre_rst_valid", 64'(b0.out_valid), 64'd1);
    chk("pre_rst_ptr", 64'(u1.g_rr.r_ptr), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(b0.out_valid), 64'd0);
    chk("arst_data", b0.out_data, 64'd0);
    chk("arst_src", 64'(b0.out_src), 64'd0);
    chk("arst_ptr", 64'(u1.g_rr.r_ptr), 64'd0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset = 1'b0;

    // Random traffic on all builds.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 4; d++) begin
        t_val[d] = 4'($urandom);
        t_sel[d] = 2'($urandom_range(0, 3));
        t_rdy[d] = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < 4; k++) td[d][k] = {$urandom, $urandom};
      end
      step();
    end

    // Drain, then every accepted word must have come out.
    for (int d = 0; d < 4; d++) begin
      t_val[d] = '0; t_rdy[d] = 1'b1;
    end
    step();
    step();
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("d%0d_sb_drained", d), 64'(wp[d] - rp[d]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muxn_reg.md
Name: muxn_reg

Overview:
Parametrised N-input, WIDTH-bit multiplexer with a registered output and valid/ready handshakes on every input and on the output. It generalises the fixed 2:1 64-bit datapath mux to any channel count. It adds two select modes: an externally driven select, or internal round-robin arbitration among valid inputs. It sits between CPU datapath producers (e.g. writeback sources, forwarding paths) and a single consumer that may stall.

Parameters:
WIDTH, 64, data bits per channel (>=1)
N, 4, number of input channels (>=2)
MODE, 0, 0 = external select via sel; 1 = round-robin arbitration (sel ignored)
SELW, $clog2(N), width of sel/out_src (derived; do not override)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_data  input  [N-1:0][WIDTH-1:0]  per-channel data
in_valid  input  [N-1:0]  per-channel valid
in_ready  output  [N-1:0]  per-channel ready (combinational)
sel  input  SELW  channel select, MODE 0 only
out_data  output  WIDTH  registered selected data
out_valid  output  1  output register holds a word
out_ready  input  1  consumer accepts
out_src  output  SELW  index of channel that produced out_data

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, rr pointer=0. Reset during a stall drops the held word.
- load_en = !out_valid || out_ready. A single-entry output stage gives 1-cycle latency and 1 word/cycle throughput.
- Input transfer on channel k: in_valid[k] && in_ready[k]. At most one in_ready bit is high per cycle. in_ready never depends on in_valid[k] of the same channel in MODE 0.
- MODE 0:
  - in_ready[sel] = load_en, all other bits 0.
  - sel >= N: all in_ready = 0 and no load.
  - If in_valid[sel] is 0, no load occurs, and out_valid falls after the current word drains.
- MODE 1:
  - Granted channel g is the first k with in_valid[k]=1, searching from ptr upward and wrapping N-1 -> 0.
  - in_ready[g] = load_en. With no valid inputs, no grant and all in_ready = 0.
  - On an accepted transfer, ptr <= (g+1) mod N, with explicit wrap for non-power-of-2 N. ptr holds otherwise, including while stalled.
- On load: out_data <= in_data[g], out_src <= g, out_valid <= 1.
- If out_valid && out_ready and there is no load, out_valid <= 0.
- Simultaneous drain and load is one cycle and bubble-free.
- Stall hold: while out_valid && !out_ready, out_data and out_src are stable and no input is accepted.
- Inputs are not required to hold in_valid without ready (no AXI-style stickiness assumed). The arbiter re-evaluates every cycle.
- There is no combinational path from in_data to out_data. in_ready depends combinationally on out_ready, out_valid, sel/in_valid and ptr.

Decomposition:
- Package mux_pkg: MODE_EXT=0 and MODE_RR=1 constants, plus a sel_idx_t typedef helper for SELW.
- Sub-module rr_pick: combinational; inputs req[N-1:0] and ptr; outputs gnt_idx and gnt_any. It is instantiated only when MODE=1, via a generate.
- The datapath select is an indexed read of in_data.

Test Plan:
- Reset, then N=4 MODE 0 with sel=2, in_valid=4'b0100, in_data[2]=64'hDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, out_data=DEAD_BEEF, out_src=2, in_ready=4'b0100.
- MODE 0 stall: hold out_ready=0 for 3 cycles while in_data[2] changes -> out_data stays DEAD_BEEF, in_ready=0. Release -> next word loads in the same cycle as the drain, with no bubble.
- MODE 1, all 4 channels valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1. With only channels 1 and 3 valid -> 1,3,1,3.
- MODE 1 with N=3 (non-power-of-2): ptr wraps 2 -> 0. Drive sel=3 in a MODE 0 N=3 build -> in_ready=0 and no load.
- Assert reset asynchronously mid-stall with out_valid=1 -> out_valid=0, out_data=0, out_src=0, and ptr=0 immediately, before the next clk edge.
- Randomised mix of valid and out_ready against a scoreboard model -> every accepted input appears exactly once, in order, with the correct out_src.
